// File: rtl/imem_loader.sv
// Program loader and instruction-memory port arbiter: streams words into the
// memory over a valid/ready handshake, then hands the address port to the core.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   core_pc,
  output logic          core_run,
  output logic [31:0]   mem_a,
  output logic          mem_we,
  output logic [31:0]   mem_wd,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);

  // Handshake: a word transfers on a rising edge where ld_valid && ld_ready;
  // ld_data/ld_last are sampled only then, and ld_valid may be held across
  // consecutive edges to transfer one word per cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic          r_ld_ready;
  logic          r_core_run;
  logic          r_we;
  logic [31:0]   r_wa;
  logic [31:0]   r_wd;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_at_end;
  logic [31:0]   w_ptr_byte;

  assign w_accept   = ld_valid && r_ld_ready;
  assign w_at_end   = (r_ptr == CW'(DEPTH - 1));
  assign w_ptr_byte = 32'(r_ptr) << 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      r_ld_ready <= 1'b0;
      r_core_run <= 1'b0;
      r_we       <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state != S_LOAD && start) begin
        // Every (re)load starts from word 0 with the core held off.
        r_state    <= S_LOAD;
        r_ld_ready <= 1'b1;
        r_core_run <= 1'b0;
        r_ptr      <= '0;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_accept) begin
              r_we    <= 1'b1;
              r_wa    <= w_ptr_byte;
              r_wd    <= ld_data;
              r_ptr   <= r_ptr + CW'(1);
              r_count <= r_count + CW'(1);
              if (ld_last) begin
                r_state    <= S_DONE;
                r_ld_ready <= 1'b0;
                r_done     <= 1'b1;
              end else if (w_at_end) begin
                // Memory is full and more words are coming: stop accepting.
                r_state    <= S_ERR;
                r_ld_ready <= 1'b0;
                r_err      <= 1'b1;
              end
            end
          end
          S_DONE: begin
            // Released one cycle after entry, so the final write completes first.
            r_core_run <= 1'b1;
          end
          default: begin
            r_core_run <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_a     = r_core_run ? core_pc : r_wa;
  assign ld_ready  = r_ld_ready;
  assign core_run  = r_core_run;
  assign mem_we    = r_we;
  assign mem_wd    = r_wd;
  assign count     = r_count;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (DEPTH=4): scoreboarded write stream, done/err flow,
// reload, overflow, throttling and asynchronous reset mid-load.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [31:0]   core_pc;
  logic          core_run;
  logic [31:0]   mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [CW-1:0] count;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .core_pc   (core_pc),
    .core_run  (core_run),
    .mem_a     (mem_a),
    .mem_we    (mem_we),
    .mem_wd    (mem_wd),
    .count     (count),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          exp_ptr  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every pulse must match the oldest accepted word.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      check_eq("we_while_run", 64'(core_run), 64'd0);
      check_eq("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(mem_a), 64'(e[63:32]));
        check_eq("wr_data", 64'(mem_wd), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one word and waits (bounded) for the handshake edge.
  task automatic send_word(input logic [31:0] d, input logic last, output bit acc);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    acc      = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      if (ld_ready === 1'b1) begin
        exp_q.push_back({32'(exp_ptr * 4), d});
        exp_ptr++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ld_ready"}, 64'(ld_ready), 64'd0);
    check_eq({pfx, "_core_run"}, 64'(core_run), 64'd0);
    check_eq({pfx, "_mem_we"},   64'(mem_we),   64'd0);
    check_eq({pfx, "_mem_a"},    64'(mem_a),    64'd0);
    check_eq({pfx, "_mem_wd"},   64'(mem_wd),   64'd0);
    check_eq({pfx, "_count"},    64'(count),    64'd0);
    check_eq({pfx, "_done"},     64'(done),     64'd0);
    check_eq({pfx, "_err"},      64'(err),      64'd0);
  endtask

  logic [31:0] prog [4];
  bit          acc;
  int unsigned c0;

  // ---------------- main sequence ----------------
  initial begin
    prog[0] = 32'h000000B3;
    prog[1] = 32'h00000233;
    prog[2] = 32'h00A08113;
    prog[3] = 32'h000081B3;
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    core_pc = 32'h8;

    // Reset then idle
    #23;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_ld_ready", 64'(ld_ready), 64'd0);
    end
    check_eq("idle_state", 64'(dbg_state), 64'd0);

    // Basic 4-word back-to-back load (last word also fills the memory)
    pulse_start();
    check_eq("load_ld_ready", 64'(ld_ready), 64'd1);
    check_eq("load_state", 64'(dbg_state), 64'd1);
    exp_ptr = 0; wr_cnt = 0; c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send_word(prog[i], i == 3, acc);
      check_eq("basic_accept", 64'(acc), 64'd1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("basic_no_bubbles", 64'(cyc - c0), 64'd4);
    check_eq("basic_done", 64'(done), 64'd1);
    check_eq("basic_count", 64'(count), 64'd4);
    check_eq("basic_run_t1", 64'(core_run), 64'd0);
    check_eq("basic_ready_off", 64'(ld_ready), 64'd0);
    tick();
    check_eq("basic_run_t2", 64'(core_run), 64'd1);
    check_eq("basic_mem_a_pc", 64'(mem_a), 64'h8);
    core_pc = 32'h0000_1236;
    #1;
    check_eq("basic_mem_a_pc2", 64'(mem_a), 64'h1236);
    check_eq("basic_wr_cnt", 64'(wr_cnt), 64'd4);
    check_eq("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Reload from DONE
    pulse_start();
    check_eq("reload_run", 64'(core_run), 64'd0);
    check_eq("reload_done", 64'(done), 64'd0);
    check_eq("reload_count", 64'(count), 64'd0);
    check_eq("reload_ld_ready", 64'(ld_ready), 64'd1);
    exp_ptr = 0; wr_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      send_word(32'hC0DE_0000 | 32'($urandom_range(0, 16'hFFFF)), i == 1, acc);
      check_eq("reload_accept", 64'(acc), 64'd1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check_eq("reload_count2", 64'(count), 64'd2);
    check_eq("reload_wr_cnt", 64'(wr_cnt), 64'd2);
    check_eq("reload_q_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: 5 words, last only on the 5th
    pulse_start();
    exp_ptr = 0; wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(32'($urandom), 1'b0, acc);
      check_eq("ovf_accept", 64'(acc), 64'd1);
    end
    check_eq("ovf_err", 64'(err), 64'd1);
    check_eq("ovf_ld_ready", 64'(ld_ready), 64'd0);
    check_eq("ovf_run", 64'(core_run), 64'd0);
    check_eq("ovf_done", 64'(done), 64'd0);
    check_eq("ovf_count", 64'(count), 64'd4);
    check_eq("ovf_state", 64'(dbg_state), 64'd3);
    send_word(32'hDEAD_BEEF, 1'b1, acc);
    check_eq("ovf_5th_refused", 64'(acc), 64'd0);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check_eq("ovf_run_hold", 64'(core_run), 64'd0);
    check_eq("ovf_wr_cnt", 64'(wr_cnt), 64'd4);
    check_eq("ovf_q_empty", 64'(exp_q.size()), 64'd0);

    // Restart from ERR, then a throttled 3-word load
    pulse_start();
    check_eq("err_cleared", 64'(err), 64'd0);
    check_eq("err_restart_state", 64'(dbg_state), 64'd1);
    exp_ptr = 0; wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      send_word(32'($urandom), i == 2, acc);
      check_eq("thr_accept", 64'(acc), 64'd1);
      ld_valid = 1'b0;
      ld_data  = 32'hBAD0_BAD0;
      ld_last  = 1'b1;
      tick();
    end
    ld_last = 1'b0;
    check_eq("thr_wr_cnt", 64'(wr_cnt), 64'd3);
    check_eq("thr_count", 64'(count), 64'd3);
    check_eq("thr_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset after 2 of 4 words
    pulse_start();
    exp_ptr = 0; wr_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      send_word(prog[i], 1'b0, acc);
      check_eq("mid_accept", 64'(acc), 64'd1);
    end
    ld_data = prog[2];
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    ld_valid = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("midrst_no_we", 64'(wr_cnt), 64'd0);
    check_eq("midrst_ld_ready", 64'(ld_ready), 64'd0);
    pulse_start();
    exp_ptr = 0;
    send_word(prog[3], 1'b1, acc);
    check_eq("midrst_reload_accept", 64'(acc), 64'd1);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check_eq("midrst_reload_wr", 64'(wr_cnt), 64'd1);
    check_eq("midrst_reload_q", 64'(exp_q.size()), 64'd0);
    check_eq("midrst_reload_run", 64'(core_run), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog timeout @%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and access arbiter for the single-port instruction memory. Streams 32-bit words into instruction memory over a valid/ready handshake, keeps the core out of execution while loading, and then hands the memory address port to the core fetch PC. Sits between the testbench/boot source, the instruction memory and the core's fetch stage.

## Interface
- DEPTH, 64: instruction memory depth in 32-bit words (≥2).
- CW, $clog2(DEPTH+1): width of the word counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a (re)load.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  qualifies ld_data as the final word of the program.
- ld_ready  out  1  block can accept a word.
- core_pc  in  32  core fetch byte address.
- core_run  out  1  core may execute; low holds the core stalled/in reset.
- mem_a  out  32  memory byte address (word aligned on writes).
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- count  out  CW  words written in the current load.
- done  out  1  load completed successfully.
- err  out  1  overflow: program longer than DEPTH words.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset state is IDLE.
- IDLE: ld_ready=0, core_run=0. On start, go to LOAD, clear count, clear done and err, and set ptr=0.
- LOAD: ld_ready=1. A word is accepted when ld_valid && ld_ready. On acceptance:
  - Register mem_we=1, mem_wa=ptr<<2 and mem_wd=ld_data for the next cycle.
  - Increment ptr and count.
- Transitions on acceptance:
  - If ld_last=1, go to DONE, whatever the value of ptr.
  - Else if ptr==DEPTH-1, write the word and go to ERR, because there is no room for the next word.
  - Otherwise stay in LOAD.
- DONE: done=1, ld_ready=0. core_run=1 starting the cycle after the final write pulse. start returns to LOAD: core_run drops the cycle after the start pulse, and count, done and ptr are cleared.
- ERR: err=1, core_run=0, ld_ready=0. start returns to LOAD and clears err.
- start is ignored while in LOAD.
- Address mux: mem_a = core_run ? core_pc : mem_wa. This mux is combinational. core_pc passes through unmodified; alignment is the core's concern.
- mem_we is only ever asserted while core_run=0.
- Reset mid-load: all state is lost. The returned state is IDLE, and no partial write pulse is issued after rst_n deasserts.

## Timing
- Reset values: ld_ready=0, core_run=0, mem_we=0, mem_wa=0, mem_wd=0, count=0, done=0, err=0. mem_a therefore reads 0.
- start at cycle t: state is LOAD at t+1, and ld_ready=1 at t+1.
- Handshake at cycle t: mem_we, mem_wa and mem_wd are valid at t+1 for exactly one cycle, and count updates at t+1.
- Back-to-back words: one word is accepted per cycle with ld_valid held high. There are no bubbles.
- ld_last accepted at cycle t: state DONE and done=1 at t+1, the last write pulse at t+1, core_run=1 at t+2.
- Overflow word accepted at t: that word is written at t+1, and err=1 at t+1.
- ld_data and ld_last are sampled only on the handshake cycle.

## Test plan
- **Reset then idle:** assert rst_n=0, then release and idle 5 cycles. Required: all outputs at reset values, and ld_ready=0 with no start.
- **Basic 4-word load:** start, then stream 0x000000B3, 0x00000233, 0x00A08113, 0x000081B3 back-to-back, with last on the 4th word. Required:
  - mem_we pulses at addresses 0x0, 0x4, 0x8, 0xC with matching data.
  - count=4 and done=1.
  - core_run=1 two cycles after the final handshake.
  - mem_a then follows core_pc=0x8.
- **Throttled loader:** ld_valid toggles every other cycle over 3 words. Required: exactly 3 write pulses, no duplicate or missing writes, and correct consecutive addresses.
- **Overflow with DEPTH=4:** stream 5 words, with last only on the 5th. Required:
  - 4 writes, at 0x0 through 0xC.
  - err=1 after the 4th handshake, ld_ready=0, core_run stays 0, and the 5th word is never written.
- **Reload from DONE:** after a successful load, pulse start. Required: core_run=0 on the next cycle, done=0, count=0, and a new load writes from address 0 again.
- **Reset mid-load:** assert rst_n low after 2 of 4 words. Required:
  - Outputs return to reset values asynchronously.
  - No mem_we after release.
  - Next start reloads from address 0.
